// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds the state encoding and the byte-mask merge helper.
package dmem_pkg;

    localparam logic [63:0] BASE_DEF  = 64'h0000_0000_8000_0000;
    localparam int          DEPTH_DEF = 256;
    localparam int          DATA_W    = 64;
    localparam int          MASK_W    = DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [MASK_W-1:0] mask
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < MASK_W; b++) begin
            if (mask[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the core and the data-memory responder.
// The core side is the master, the responder side is the slave.
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [63:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr,
        output req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid,
        input  resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr,
        input  req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid,
        output resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 64 storage with byte-masked synchronous write and async read.
// Contents are deliberately left untouched by reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [IW-1:0]     i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [MASK_W-1:0] i_wmask,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= merge_bytes(r_mem[i_idx], i_wdata, i_wmask);
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-cycle-latency data-memory responder with range/alignment checks.
// One response register; accepts back-to-back when the core drains it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [63:0] BASE  = BASE_DEF,
    parameter int          DEPTH = DEPTH_DEF
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);

    localparam int          IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] LIMIT = 64'(DEPTH) << 3;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              r_err;
    logic              w_err_nxt;

    logic [63:0]       w_off;
    logic [IW-1:0]     w_idx;
    logic              w_bad;
    logic              w_accept;
    logic              w_we;
    logic [DATA_W-1:0] w_rd;

    // Below-base addresses wrap to huge offsets and fail the limit check.
    assign w_off = bus.req_addr - BASE;
    assign w_bad = (bus.req_addr[2:0] != 3'b000) || (w_off >= LIMIT);
    assign w_idx = w_off[IW+2:3];

    assign bus.req_ready = !rst && ((r_state == IDLE) || bus.resp_ready);
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_we          = w_accept && bus.req_write && !w_bad;

    dmem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (bus.req_wdata),
        .i_wmask (bus.req_wmask),
        .o_rdata (w_rd)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (w_accept) begin
                    w_state_nxt = RESP;
                end else if (bus.resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_accept) begin
            w_rdata_nxt = (w_bad || bus.req_write) ? '0 : w_rd;
            w_err_nxt   = w_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a word-array model.
// The model tracks one pending response and the memory image.
module tb_dmem_responder;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 256;
    localparam logic [63:0] TOP   = BASE + 64'(DEPTH) * 64'd8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_if bus();

    dmem_responder #(
        .BASE  (BASE),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] mm [DEPTH];
    bit          e_valid = 1'b0;
    logic [63:0] e_rdata = '0;
    bit          e_err   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(input logic [63:0] a);
        return (a % 8 != 0) || (a < BASE) || (a >= TOP);
    endfunction

    task automatic cyc(input bit v, input bit w, input logic [63:0] a,
                       input logic [63:0] d, input logic [7:0] m,
                       input bit rr);
        bit acc;
        int idx;
        bus.req_valid  = v;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.req_wmask  = m;
        bus.resp_ready = rr;
        #1;
        chk("resp_valid", 64'(bus.resp_valid), 64'(e_valid));
        if (e_valid) begin
            chk("resp_rdata", bus.resp_rdata, e_rdata);
            chk("resp_err", 64'(bus.resp_err), 64'(e_err));
        end
        chk("req_ready", 64'(bus.req_ready), 64'(!e_valid || rr));
        acc = v && (!e_valid || rr);
        @(posedge clk);
        if (acc) begin
            e_valid = 1'b1;
            if (is_bad(a)) begin
                e_err   = 1'b1;
                e_rdata = '0;
            end else begin
                e_err = 1'b0;
                idx   = int'((a - BASE) / 8);
                if (w) begin
                    for (int b = 0; b < 8; b++)
                        if (m[b]) mm[idx][b*8 +: 8] = d[b*8 +: 8];
                    e_rdata = '0;
                end else begin
                    e_rdata = mm[idx];
                end
            end
        end else if (rr) begin
            e_valid = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input bit rr);
        cyc(1'b0, 1'b0, '0, '0, '0, rr);
    endtask

    initial begin
        logic [63:0] a;
        int          r;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wmask  = '0;
        bus.resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        #1;
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First post-reset cycle: fill the whole array back-to-back.
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 1'b1, BASE + 64'(i) * 8,
                {$urandom, $urandom}, 8'hFF, 1'b1);
        idle(1'b1);

        cyc(1'b1, 1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 1'b1);
        cyc(1'b1, 1'b0, 64'h8000_0008, '0, '0, 1'b1);
        chk("full_store_load", bus.resp_rdata, 64'h1122_3344_5566_7788);
        idle(1'b1);

        cyc(1'b1, 1'b1, 64'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 1'b1);
        cyc(1'b1, 1'b0, 64'h8000_0008, '0, '0, 1'b1);
        chk("partial_store", bus.resp_rdata, 64'h1122_3344_BBBB_BBBB);

        cyc(1'b1, 1'b0, 64'h8000_0004, '0, '0, 1'b1);
        chk("misalign_err", 64'(bus.resp_err), 64'd1);
        chk("misalign_rdata", bus.resp_rdata, 64'd0);
        cyc(1'b1, 1'b0, 64'h8000_0800, '0, '0, 1'b1);
        chk("range_err", 64'(bus.resp_err), 64'd1);
        chk("range_rdata", bus.resp_rdata, 64'd0);
        cyc(1'b1, 1'b1, 64'h7FFF_FFF8, '1, 8'hFF, 1'b1);
        chk("below_err", 64'(bus.resp_err), 64'd1);
        cyc(1'b1, 1'b1, 64'h8000_0008, '1, 8'h00, 1'b1);
        chk("mask0_err", 64'(bus.resp_err), 64'd0);
        cyc(1'b1, 1'b0, 64'h8000_0008, '0, '0, 1'b1);
        chk("mem_unchanged", bus.resp_rdata, 64'h1122_3344_BBBB_BBBB);
        idle(1'b1);

        // Stall with a pending response, then release with a new request.
        cyc(1'b1, 1'b0, 64'h8000_0010, '0, '0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 64'h8000_0008, '0, '0, 1'b0);
        cyc(1'b1, 1'b0, 64'h8000_0008, '0, '0, 1'b1);
        chk("after_stall", bus.resp_rdata, 64'h1122_3344_BBBB_BBBB);
        idle(1'b1);

        cyc(1'b1, 1'b0, 64'h8000_0010, '0, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(bus.resp_valid), 64'd0);
        chk("async_rst_ready", 64'(bus.req_ready), 64'd0);
        e_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 64'h8000_0008, '0, '0, 1'b1);
        chk("post_rst_data", bus.resp_rdata, 64'h1122_3344_BBBB_BBBB);
        idle(1'b1);

        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b0, BASE + 64'(i) * 8, '0, '0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 8;
            if (r == 0) a = a + 64'($urandom_range(1, 7));
            else if (r == 1) a = BASE - 64'($urandom_range(1, 64)) * 8;
            else if (r == 2) a = TOP + 64'($urandom_range(0, 64)) * 8;
            else if (r == 3) a = {$urandom, $urandom};
            cyc(($urandom % 4) != 0, $urandom % 2, a,
                {$urandom, $urandom},
                (($urandom % 8) == 0) ? 8'h00 : 8'($urandom),
                ($urandom % 4) != 0);
        end
        idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
